lct_quality_monitor: RTL and testbench
======================================

Name: lct_quality_monitor

Overview:
- Receive-side counterpart of the TMB LCT quality encoder.
- Takes the 4-bit LCT quality Q as it leaves the TMB, decodes it back into its source categories, and registers the category flags.
- Keeps a saturating per-Q histogram with a snapshot/clear handshake, so slow control can read quality statistics without losing events.
- Sits beside the MPC output path; its inputs are the registered LCT valid and quality bits.

Parameters:
- CNT_WIDTH, 16, width of each live and snapshot histogram counter.
- RST_RUN, 0, FSM state after reset: 0 = IDLE, 1 = RUN.

Ports:
- clock  in  1  main 40 MHz clock
- global_reset  in  1  synchronous, active-high reset
- run_en  in  1  level; enables histogramming
- lct0_vpf  in  1  first LCT valid this bx
- lct0_q  in  4  first LCT quality
- snap_req  in  1  level request to snapshot and clear the live counters
- snap_done  out  1  high from snapshot completion until snap_req drops
- cnt_sel  in  4  selects the snapshot counter (Q value) to read
- cnt_rd_data  out  CNT_WIDTH  selected snapshot counter, registered
- dec_valid  out  1  decoded flags valid, 1-cycle latency
- dec_hq  out  1  Q in 11..15: high-quality matched muon
- dec_bend  out  3  for Q 11..15: Q-11 (0 = steepest group, 4 = straight); else 0
- dec_accel  out  1  Q==8: high-quality muon with accelerator ALCT
- dec_marg_a  out  1  Q==7 or Q==5: marginal anode
- dec_marg_c  out  1  Q==6 or Q==5: marginal cathode
- dec_layer  out  1  Q==3: match with layer-trigger CLCT
- dec_clct_only  out  1  Q==2
- dec_alct_only  out  1  Q==1
- dec_reserved  out  1  Q in {0,4,9,10}: should never occur
- err_cnt  out  CNT_WIDTH  saturating count of reserved-Q LCTs; live counter, cleared with the histogram
- busy  out  1  FSM is not in IDLE

Behaviour:
- Reset:
  - All outputs, all live and snapshot counters, and err_cnt go to 0.
  - FSM goes to IDLE, or RUN if RST_RUN=1.
- Decode pipeline:
  - On lct0_vpf at cycle N, the dec_* flags and dec_valid=1 appear at N+1. dec_valid=0 otherwise; the flags are then 0.
  - Decode runs in every FSM state.
  - Flags are mutually exclusive except dec_marg_a and dec_marg_c, which are both set for Q==5.
- FSM states:
  - IDLE → RUN when run_en=1.
  - RUN → IDLE when run_en=0.
  - RUN → SNAP when snap_req=1.
  - SNAP lasts one cycle, then goes to DONE.
  - DONE → RUN when snap_req=0 and run_en=1.
  - DONE → IDLE when snap_req=0 and run_en=0.
  - snap_req seen in IDLE is held until RUN is entered; it is not lost.
- Counting:
  - In RUN, SNAP and DONE, each lct0_vpf increments live counter[lct0_q] by 1.
  - Counters saturate at 2^CNT_WIDTH-1 and never wrap.
  - A reserved Q also increments err_cnt, saturating.
  - No counting in IDLE.
- Snapshot (SNAP cycle):
  - All 16 live counters are copied to the snapshot bank; the copy includes the increment of the current cycle.
  - Live counters and err_cnt are then cleared, so every event lands in exactly one interval.
- Handshakes:
  - snap_done rises the cycle after SNAP and falls the cycle after snap_req falls.
  - cnt_rd_data = snapshot[cnt_sel], one-cycle registered latency.
  - Snapshot contents are stable until the next SNAP.
- Reset mid-operation: global_reset in SNAP or DONE aborts. The snapshot bank is zeroed and snap_done drops the next cycle.

Optional Feature:
- Macro LCT_QUALITY_SECOND_EN.
- Defined:
  - Adds ports lct1_vpf (in 1), lct1_q (in 4) and a second decoded flag set with suffix _1.
  - Each counter adds 0, 1 or 2 per cycle; lct0_q==lct1_q adds 2 to one counter.
  - Saturation is computed on the sum.
  - err_cnt counts each reserved LCT, up to 2 per cycle.
- Undefined: single-LCT behaviour only; ports absent.

Decomposition:
- Package lct_quality_pkg:
  - Q code constants: Q_HQ_MIN=11, Q_HQ_MAX=15, Q_ACCEL=8, Q_MARG_A=7, Q_MARG_C=6, Q_MARG_AC=5, Q_LAYER=3, Q_CLCT_ONLY=2, Q_ALCT_ONLY=1.
  - Reserved set {0,4,9,10}.
  - FSM state encoding {IDLE, RUN, SNAP, DONE}.
- Sub-module lct_sat_counter:
  - CNT_WIDTH-bit saturating counter with a 2-bit increment input and synchronous clear.
  - Instantiated 17 times (16 histogram bins + err_cnt).

Test Plan:
- Reset, run_en=1, lct0_vpf=1 with lct0_q=15 for 3 cycles → dec_hq=1, dec_bend=4 at N+1. Then snap_req=1 → snap_done=1; cnt_sel=15 gives 3 after one cycle; cnt_sel=14 gives 0.
- Sweep Q=0..15, one per cycle → exactly one flag per Q except Q=5 (both marg flags). dec_reserved=1 only for Q=0,4,9,10; err_cnt=4.
- CNT_WIDTH=4, 20 LCTs with Q=2 → snapshot[2]=15 (saturated, no wrap).
- LCT with Q=7 on the SNAP cycle → counted in snapshot[7]. Live counter[7]=0 afterwards; the next snapshot shows only events after SNAP.
- run_en=0, 5 LCTs with Q=12 → dec flags toggle, counter[12] stays 0. snap_req held in IDLE, then run_en=1 → SNAP occurs within 2 cycles.
- global_reset asserted in DONE → snap_done=0 and cnt_rd_data=0 the next cycle. With LCT_QUALITY_SECOND_EN, lct0_q=lct1_q=11 for 1 cycle → snapshot[11]=2.

Source files
------------

// File: rtl/lct_quality_pkg.sv
// LCT quality code map, FSM encoding and decode helpers
// shared by the receive-side quality monitor.
package lct_quality_pkg;

  localparam logic [3:0] Q_HQ_MIN    = 4'd11;
  localparam logic [3:0] Q_HQ_MAX    = 4'd15;
  localparam logic [3:0] Q_ACCEL     = 4'd8;
  localparam logic [3:0] Q_MARG_A    = 4'd7;
  localparam logic [3:0] Q_MARG_C    = 4'd6;
  localparam logic [3:0] Q_MARG_AC   = 4'd5;
  localparam logic [3:0] Q_LAYER     = 4'd3;
  localparam logic [3:0] Q_CLCT_ONLY = 4'd2;
  localparam logic [3:0] Q_ALCT_ONLY = 4'd1;

  localparam int N_BINS = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_SNAP,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic       hq;
    logic [2:0] bend;
    logic       accel;
    logic       marg_a;
    logic       marg_c;
    logic       layer;
    logic       clct_only;
    logic       alct_only;
    logic       reserved;
  } dec_t;

  function automatic logic is_reserved(logic [3:0] q);
    return (q == 4'd0) || (q == 4'd4) ||
           (q == 4'd9) || (q == 4'd10);
  endfunction

  function automatic dec_t lct_decode(logic [3:0] q);
    dec_t d;
    logic [3:0] off;
    d = '0;
    off = q - Q_HQ_MIN;
    if (q inside {[Q_HQ_MIN:Q_HQ_MAX]}) begin
      d.hq   = 1'b1;
      d.bend = off[2:0];
    end
    d.accel     = (q == Q_ACCEL);
    d.marg_a    = (q == Q_MARG_A) || (q == Q_MARG_AC);
    d.marg_c    = (q == Q_MARG_C) || (q == Q_MARG_AC);
    d.layer     = (q == Q_LAYER);
    d.clct_only = (q == Q_CLCT_ONLY);
    d.alct_only = (q == Q_ALCT_ONLY);
    d.reserved  = is_reserved(q);
    return d;
  endfunction

endpackage

// File: rtl/lct_sat_counter.sv
// Saturating counter, 0..2 per cycle, synchronous clear.
// SHOW_NEXT selects whether val_o shows the next or current count.
module lct_sat_counter #(
  parameter int CNT_WIDTH = 16,
  parameter bit SHOW_NEXT = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic [1:0]           inc_i,
  output logic [CNT_WIDTH-1:0] val_o
);

  localparam logic [CNT_WIDTH-1:0] MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH:0]   sum;

  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_WIDTH+1)'(inc_i);
    cnt_d = (sum > {1'b0, MAX}) ? MAX : sum[CNT_WIDTH-1:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) cnt_q <= '0;
    else                cnt_q <= cnt_d;
  end

  assign val_o = SHOW_NEXT ? cnt_d : cnt_q;

endmodule

// File: rtl/lct_quality_monitor.sv
// Decodes TMB LCT quality and histograms it with snapshot/clear.
// LCT_QUALITY_SECOND_EN adds the second LCT of the bx.
module lct_quality_monitor
  import lct_quality_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int RST_RUN   = 0
) (
  input  logic                 clock,
  input  logic                 global_reset,
  input  logic                 run_en,
  input  logic                 lct0_vpf,
  input  logic [3:0]           lct0_q,
`ifdef LCT_QUALITY_SECOND_EN
  input  logic                 lct1_vpf,
  input  logic [3:0]           lct1_q,
  output logic                 dec_valid_1,
  output logic                 dec_hq_1,
  output logic [2:0]           dec_bend_1,
  output logic                 dec_accel_1,
  output logic                 dec_marg_a_1,
  output logic                 dec_marg_c_1,
  output logic                 dec_layer_1,
  output logic                 dec_clct_only_1,
  output logic                 dec_alct_only_1,
  output logic                 dec_reserved_1,
`endif
  input  logic                 snap_req,
  output logic                 snap_done,
  input  logic [3:0]           cnt_sel,
  output logic [CNT_WIDTH-1:0] cnt_rd_data,
  output logic                 dec_valid,
  output logic                 dec_hq,
  output logic [2:0]           dec_bend,
  output logic                 dec_accel,
  output logic                 dec_marg_a,
  output logic                 dec_marg_c,
  output logic                 dec_layer,
  output logic                 dec_clct_only,
  output logic                 dec_alct_only,
  output logic                 dec_reserved,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 busy
);

  localparam state_e ST_RST = (RST_RUN != 0) ? ST_RUN : ST_IDLE;

  state_e state_q, state_d;

  always_ff @(posedge clock) begin
    if (global_reset) state_q <= ST_RST;
    else              state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (run_en) state_d = ST_RUN;
      ST_RUN: begin
        if (!run_en)       state_d = ST_IDLE;
        else if (snap_req) state_d = ST_SNAP;
      end
      ST_SNAP: state_d = ST_DONE;
      ST_DONE: begin
        if (!snap_req) state_d = run_en ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic cnt_en, snap_now;
  assign cnt_en    = (state_q != ST_IDLE);
  assign snap_now  = (state_q == ST_SNAP);
  assign busy      = (state_q != ST_IDLE);
  assign snap_done = (state_q == ST_DONE);

  dec_t dec0_q;
  logic dv0_q;

  always_ff @(posedge clock) begin
    if (global_reset) begin
      dv0_q  <= 1'b0;
      dec0_q <= '0;
    end else begin
      dv0_q  <= lct0_vpf;
      dec0_q <= lct0_vpf ? lct_decode(lct0_q) : '0;
    end
  end

  assign dec_valid     = dv0_q;
  assign dec_hq        = dec0_q.hq;
  assign dec_bend      = dec0_q.bend;
  assign dec_accel     = dec0_q.accel;
  assign dec_marg_a    = dec0_q.marg_a;
  assign dec_marg_c    = dec0_q.marg_c;
  assign dec_layer     = dec0_q.layer;
  assign dec_clct_only = dec0_q.clct_only;
  assign dec_alct_only = dec0_q.alct_only;
  assign dec_reserved  = dec0_q.reserved;

`ifdef LCT_QUALITY_SECOND_EN
  dec_t dec1_q;
  logic dv1_q;

  always_ff @(posedge clock) begin
    if (global_reset) begin
      dv1_q  <= 1'b0;
      dec1_q <= '0;
    end else begin
      dv1_q  <= lct1_vpf;
      dec1_q <= lct1_vpf ? lct_decode(lct1_q) : '0;
    end
  end

  assign dec_valid_1     = dv1_q;
  assign dec_hq_1        = dec1_q.hq;
  assign dec_bend_1      = dec1_q.bend;
  assign dec_accel_1     = dec1_q.accel;
  assign dec_marg_a_1    = dec1_q.marg_a;
  assign dec_marg_c_1    = dec1_q.marg_c;
  assign dec_layer_1     = dec1_q.layer;
  assign dec_clct_only_1 = dec1_q.clct_only;
  assign dec_alct_only_1 = dec1_q.alct_only;
  assign dec_reserved_1  = dec1_q.reserved;
`endif

  // slot N_BINS is the reserved-Q error counter
  logic [1:0]           inc [N_BINS+1];
  logic [CNT_WIDTH-1:0] val [N_BINS+1];

  always_comb begin
    for (int i = 0; i <= N_BINS; i++) inc[i] = 2'd0;
    if (cnt_en) begin
      for (int i = 0; i < N_BINS; i++) begin
        if (lct0_vpf && lct0_q == 4'(i)) inc[i] = inc[i] + 2'd1;
`ifdef LCT_QUALITY_SECOND_EN
        if (lct1_vpf && lct1_q == 4'(i)) inc[i] = inc[i] + 2'd1;
`endif
      end
      if (lct0_vpf && is_reserved(lct0_q))
        inc[N_BINS] = inc[N_BINS] + 2'd1;
`ifdef LCT_QUALITY_SECOND_EN
      if (lct1_vpf && is_reserved(lct1_q))
        inc[N_BINS] = inc[N_BINS] + 2'd1;
`endif
    end
  end

  for (genvar g = 0; g <= N_BINS; g++) begin : g_cnt
    lct_sat_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .SHOW_NEXT (g < N_BINS)
    ) u_cnt (
      .clk_i (clock),
      .rst_i (global_reset),
      .clr_i (snap_now),
      .inc_i (inc[g]),
      .val_o (val[g])
    );
  end

  assign err_cnt = val[N_BINS];

  logic [CNT_WIDTH-1:0] snap_q [N_BINS];
  logic [CNT_WIDTH-1:0] rd_q;

  // bins expose next-count, so the copy includes this cycle's LCT
  always_ff @(posedge clock) begin
    if (global_reset) begin
      for (int i = 0; i < N_BINS; i++) snap_q[i] <= '0;
      rd_q <= '0;
    end else begin
      if (snap_now)
        for (int i = 0; i < N_BINS; i++) snap_q[i] <= val[i];
      rd_q <= snap_q[cnt_sel];
    end
  end

  assign cnt_rd_data = rd_q;

endmodule

// File: tb/tb_lct_quality_monitor.sv
// Directed bench for lct_quality_monitor (CNT_WIDTH=4).
// Honours LCT_QUALITY_SECOND_EN when defined.
module tb_lct_quality_monitor;

  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          global_reset;
  logic          run_en;
  logic          lct0_vpf;
  logic [3:0]    lct0_q;
  logic          snap_req;
  logic          snap_done;
  logic [3:0]    cnt_sel;
  logic [CW-1:0] cnt_rd_data;
  logic          dec_valid;
  logic          dec_hq;
  logic [2:0]    dec_bend;
  logic          dec_accel;
  logic          dec_marg_a;
  logic          dec_marg_c;
  logic          dec_layer;
  logic          dec_clct_only;
  logic          dec_alct_only;
  logic          dec_reserved;
  logic [CW-1:0] err_cnt;
  logic          busy;
`ifdef LCT_QUALITY_SECOND_EN
  logic          lct1_vpf;
  logic [3:0]    lct1_q;
  logic          dec_valid_1, dec_hq_1, dec_accel_1;
  logic [2:0]    dec_bend_1;
  logic          dec_marg_a_1, dec_marg_c_1, dec_layer_1;
  logic          dec_clct_only_1, dec_alct_only_1, dec_reserved_1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  lct_quality_monitor #(
    .CNT_WIDTH (CW),
    .RST_RUN   (0)
  ) dut (
    .clock         (clock),
    .global_reset  (global_reset),
    .run_en        (run_en),
    .lct0_vpf      (lct0_vpf),
    .lct0_q        (lct0_q),
`ifdef LCT_QUALITY_SECOND_EN
    .lct1_vpf        (lct1_vpf),
    .lct1_q          (lct1_q),
    .dec_valid_1     (dec_valid_1),
    .dec_hq_1        (dec_hq_1),
    .dec_bend_1      (dec_bend_1),
    .dec_accel_1     (dec_accel_1),
    .dec_marg_a_1    (dec_marg_a_1),
    .dec_marg_c_1    (dec_marg_c_1),
    .dec_layer_1     (dec_layer_1),
    .dec_clct_only_1 (dec_clct_only_1),
    .dec_alct_only_1 (dec_alct_only_1),
    .dec_reserved_1  (dec_reserved_1),
`endif
    .snap_req      (snap_req),
    .snap_done     (snap_done),
    .cnt_sel       (cnt_sel),
    .cnt_rd_data   (cnt_rd_data),
    .dec_valid     (dec_valid),
    .dec_hq        (dec_hq),
    .dec_bend      (dec_bend),
    .dec_accel     (dec_accel),
    .dec_marg_a    (dec_marg_a),
    .dec_marg_c    (dec_marg_c),
    .dec_layer     (dec_layer),
    .dec_clct_only (dec_clct_only),
    .dec_alct_only (dec_alct_only),
    .dec_reserved  (dec_reserved),
    .err_cnt       (err_cnt),
    .busy          (busy)
  );

  // {hq, bend[2:0], accel, marg_a, marg_c, layer, clct, alct, reserved}
  logic [10:0] flags;
  assign flags = {dec_hq, dec_bend, dec_accel, dec_marg_a, dec_marg_c,
                  dec_layer, dec_clct_only, dec_alct_only, dec_reserved};

  logic [10:0] exp_tab [16] = '{
    11'b0_000_0000001,  // 0 reserved
    11'b0_000_0000010,  // 1 alct only
    11'b0_000_0000100,  // 2 clct only
    11'b0_000_0001000,  // 3 layer
    11'b0_000_0000001,  // 4 reserved
    11'b0_000_0110000,  // 5 marg a+c
    11'b0_000_0010000,  // 6 marg c
    11'b0_000_0100000,  // 7 marg a
    11'b0_000_1000000,  // 8 accel
    11'b0_000_0000001,  // 9 reserved
    11'b0_000_0000001,  // 10 reserved
    11'b1_000_0000000,  // 11 hq bend 0
    11'b1_001_0000000,  // 12
    11'b1_010_0000000,  // 13
    11'b1_011_0000000,  // 14
    11'b1_100_0000000   // 15
  };

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    global_reset = 1'b1;
    run_en       = 1'b0;
    lct0_vpf     = 1'b0;
    lct0_q       = 4'd0;
    snap_req     = 1'b0;
    cnt_sel      = 4'd0;
`ifdef LCT_QUALITY_SECOND_EN
    lct1_vpf     = 1'b0;
    lct1_q       = 4'd0;
`endif
    step();
    step();
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_snap_done", 32'(snap_done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_rd_data", 32'(cnt_rd_data), 32'd0);
    global_reset = 1'b0;

    // three Q=15 LCTs, then snapshot
    run_en = 1'b1;
    step();
    chk("t1_busy", 32'(busy), 32'd1);
    lct0_vpf = 1'b1;
    lct0_q   = 4'd15;
    step();
    chk("t1_dec_valid", 32'(dec_valid), 32'd1);
    chk("t1_flags", 32'(flags), 32'(exp_tab[15]));
    step();
    step();
    lct0_vpf = 1'b0;
    step();
    chk("t1_dec_valid_off", 32'(dec_valid), 32'd0);
    chk("t1_flags_off", 32'(flags), 32'd0);
    snap_req = 1'b1;
    step();
    chk("t1_snap_done_snap", 32'(snap_done), 32'd0);
    step();
    chk("t1_snap_done", 32'(snap_done), 32'd1);
    cnt_sel = 4'd15;
    step();
    chk("t1_rd15", 32'(cnt_rd_data), 32'd3);
    cnt_sel = 4'd14;
    step();
    chk("t1_rd14", 32'(cnt_rd_data), 32'd0);
    snap_req = 1'b0;
    step();
    chk("t1_snap_done_fall", 32'(snap_done), 32'd0);
    chk("t1_busy_run", 32'(busy), 32'd1);

    // sweep every Q code
    lct0_vpf = 1'b1;
    for (int q = 0; q < 16; q++) begin
      lct0_q = 4'(q);
      step();
      chk($sformatf("sweep_q%0d", q), 32'(flags), 32'(exp_tab[q]));
    end
    chk("sweep_err_cnt", 32'(err_cnt), 32'd4);
    lct0_vpf = 1'b0;

    // saturation of a 4-bit bin (1 from sweep + 20)
    lct0_vpf = 1'b1;
    lct0_q   = 4'd2;
    repeat (20) step();
    lct0_vpf = 1'b0;
    snap_req = 1'b1;
    step();
    step();
    chk("t3_snap_done", 32'(snap_done), 32'd1);
    chk("t3_err_cleared", 32'(err_cnt), 32'd0);
    cnt_sel = 4'd2;
    step();
    chk("t3_rd2_sat", 32'(cnt_rd_data), 32'd15);
    cnt_sel = 4'd5;
    step();
    chk("t3_rd5", 32'(cnt_rd_data), 32'd1);
    snap_req = 1'b0;
    step();

    // LCT on the SNAP cycle lands in that snapshot
    snap_req = 1'b1;
    step();
    lct0_vpf = 1'b1;
    lct0_q   = 4'd7;
    step();
    lct0_vpf = 1'b0;
    cnt_sel  = 4'd7;
    step();
    chk("t4_rd7_on_snap", 32'(cnt_rd_data), 32'd1);
    snap_req = 1'b0;
    step();
    lct0_vpf = 1'b1;
    repeat (2) step();
    lct0_vpf = 1'b0;
    snap_req = 1'b1;
    step();
    step();
    step();
    chk("t4_rd7_next", 32'(cnt_rd_data), 32'd2);

    // IDLE: decode works, nothing counted, snap_req held
    snap_req = 1'b0;
    run_en   = 1'b0;
    step();
    chk("t5_idle_busy", 32'(busy), 32'd0);
    lct0_vpf = 1'b1;
    lct0_q   = 4'd12;
    repeat (5) step();
    chk("t5_idle_flags", 32'(flags), 32'(exp_tab[12]));
    lct0_vpf = 1'b0;
    step();
    chk("t5_idle_valid_off", 32'(dec_valid), 32'd0);
    snap_req = 1'b1;
    step();
    step();
    chk("t5_held_busy", 32'(busy), 32'd0);
    run_en   = 1'b1;
    lct0_vpf = 1'b1;
    lct0_q   = 4'd3;
    step();
    step();
    lct0_vpf = 1'b0;
    step();
    chk("t5_snap_done", 32'(snap_done), 32'd1);
    cnt_sel = 4'd12;
    step();
    chk("t5_rd12", 32'(cnt_rd_data), 32'd0);
    cnt_sel = 4'd3;
    step();
    chk("t5_rd3", 32'(cnt_rd_data), 32'd1);

    // reset while in DONE
    global_reset = 1'b1;
    step();
    chk("t6_snap_done", 32'(snap_done), 32'd0);
    chk("t6_rd_data", 32'(cnt_rd_data), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    global_reset = 1'b0;
    snap_req     = 1'b0;
    step();
    chk("t6_rd_after", 32'(cnt_rd_data), 32'd0);

`ifdef LCT_QUALITY_SECOND_EN
    run_en = 1'b1;
    step();
    lct0_vpf = 1'b1;
    lct0_q   = 4'd11;
    lct1_vpf = 1'b1;
    lct1_q   = 4'd11;
    step();
    chk("t7_dec_hq_1", 32'(dec_hq_1), 32'd1);
    lct0_vpf = 1'b0;
    lct1_vpf = 1'b0;
    snap_req = 1'b1;
    step();
    step();
    cnt_sel = 4'd11;
    step();
    chk("t7_rd11_pair", 32'(cnt_rd_data), 32'd2);
    snap_req = 1'b0;
    step();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
